// File: rtl/multi_sequence_ctrl.sv
// multi_sequence_ctrl: parses CH/LEN/CYC/data frames from a byte FIFO and programs NUM_CH
// looping bit-sequence generators. Define SEQ_CHECKSUM_EN to expect a trailing XOR byte.
module multi_sequence_ctrl #(
  parameter int  NUM_CH  = 4,
  parameter int  MAX_LEN = 255,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        fifo_rd_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_req,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [NUM_CH-1:0] seq
);

  localparam int NB_MAX = (MAX_LEN + 7) / 8;
  localparam int SH_W   = NB_MAX * 8;
`ifdef SEQ_CHECKSUM_EN
  localparam logic [5:0] CHK_BYTES = 6'd1;
`else
  localparam logic [5:0] CHK_BYTES = 6'd0;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CHK    = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_CH   = 3'd1;
  localparam logic [2:0] ERR_LEN  = 3'd2;
  localparam logic [2:0] ERR_CYC  = 3'd3;

  logic [2:0]      state;
  logic            rd_vld;
  logic [5:0]      req_cnt;
  logic [5:0]      rcv_cnt;
  logic [CH_W-1:0] hdr_ch;
  logic [7:0]      hdr_len;
  logic [7:0]      hdr_cyc;
  logic [5:0]      data_bytes;
  logic [5:0]      frame_bytes;
  logic [5:0]      data_idx;
  logic            need_more;
  logic [SH_W-1:0] shadow;
  logic [SH_W-1:0] len_mask;
  logic [SH_W-1:0] shadow_masked;

  logic [SH_W-1:0] ch_data [NUM_CH];
  logic [7:0]      ch_len  [NUM_CH];
  logic [7:0]      ch_cyc  [NUM_CH];
  logic [7:0]      ch_ptr  [NUM_CH];
  logic [7:0]      ch_cnt  [NUM_CH];

  assign data_bytes  = 6'((9'(hdr_len) + 9'd7) >> 3);
  assign frame_bytes = 6'd3 + data_bytes + CHK_BYTES;
  assign data_idx    = rcv_cnt - 6'd3;

  // The three header bytes are always wanted; beyond that the length is known
  // only once LEN has been captured.
  assign need_more = (req_cnt < 6'd3) || ((rcv_cnt >= 6'd2) && (req_cnt < frame_bytes));

  assign fifo_rd_req = !fifo_empty &&
                       ((((state == S_HDR) || (state == S_DATA) || (state == S_CHK)) && need_more) ||
                        (state == S_DRAIN));
  assign busy        = (state != S_IDLE);
  assign frame_done  = (state == S_COMMIT);

  always_comb begin
    // NOTE: default every bit first so no path through the loop can infer a latch.
    len_mask = '0;
    for (int i = 0; i < SH_W; i++) len_mask[i] = (i < int'(hdr_len));
    shadow_masked = shadow & len_mask;
  end

`ifdef SEQ_CHECKSUM_EN
  localparam logic [2:0] ERR_CHK = 3'd4;
  logic [7:0] xsum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               xsum <= '0;
    else if (state == S_IDLE)                              xsum <= '0;
    else if (rd_vld && ((state == S_HDR) || (state == S_DATA))) xsum <= xsum ^ fifo_rd_data;
  end
`endif

  // NOTE: all clocked state uses non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rd_vld   <= 1'b0;
      req_cnt  <= '0;
      rcv_cnt  <= '0;
      hdr_ch   <= '0;
      hdr_len  <= 8'd1;
      hdr_cyc  <= 8'd1;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      rd_vld <= fifo_rd_req;
      if (fifo_rd_req) req_cnt <= req_cnt + 6'd1;
      case (state)
        S_IDLE: begin
          req_cnt <= '0;
          rcv_cnt <= '0;
          if (!fifo_empty) state <= S_HDR;
        end
        S_HDR: if (rd_vld) begin
          rcv_cnt <= rcv_cnt + 6'd1;
          case (rcv_cnt)
            6'd0: if (fifo_rd_data >= 8'(NUM_CH)) begin
              state <= S_DRAIN; err <= 1'b1; err_code <= ERR_CH;
            end else hdr_ch <= fifo_rd_data[CH_W-1:0];
            6'd1: if ((fifo_rd_data == 8'd0) || (9'(fifo_rd_data) > 9'(MAX_LEN))) begin
              state <= S_DRAIN; err <= 1'b1; err_code <= ERR_LEN;
            end else hdr_len <= fifo_rd_data;
            default: if (fifo_rd_data == 8'd0) begin
              state <= S_DRAIN; err <= 1'b1; err_code <= ERR_CYC;
            end else begin
              hdr_cyc <= fifo_rd_data;
              state   <= S_DATA;
            end
          endcase
        end
        S_DATA: if (rd_vld) begin
          rcv_cnt <= rcv_cnt + 6'd1;
          if (rcv_cnt == 6'd2 + data_bytes) state <= (CHK_BYTES != 6'd0) ? S_CHK : S_COMMIT;
        end
`ifdef SEQ_CHECKSUM_EN
        S_CHK: if (rd_vld) begin
          if (fifo_rd_data == xsum) state <= S_COMMIT;
          else begin
            state <= S_DRAIN; err <= 1'b1; err_code <= ERR_CHK;
          end
        end
`endif
        S_COMMIT: begin
          err      <= 1'b0;
          err_code <= ERR_NONE;
          state    <= S_IDLE;
        end
        S_DRAIN: if (fifo_empty) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: shadow is plain datapath rewritten by every frame, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rd_vld && (state == S_DATA)) begin
      for (int b = 0; b < NB_MAX; b++)
        if (data_idx == 6'(b)) shadow[8*b +: 8] <= fifo_rd_data;
    end
  end

  // Per-channel generators; the committing channel restarts from bit 0 on the COMMIT edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_data[i] <= '0;
        ch_len[i]  <= 8'd1;
        ch_cyc[i]  <= 8'd1;
        ch_ptr[i]  <= '0;
        ch_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (frame_done && (hdr_ch == CH_W'(i))) begin
          ch_data[i] <= shadow_masked;
          ch_len[i]  <= hdr_len;
          ch_cyc[i]  <= hdr_cyc;
          ch_ptr[i]  <= '0;
          ch_cnt[i]  <= '0;
          seq[i]     <= shadow_masked[0];
        end else begin
          seq[i] <= ch_data[i][ch_ptr[i]];
          if (ch_cnt[i] == ch_cyc[i] - 8'd1) begin
            ch_cnt[i] <= '0;
            ch_ptr[i] <= (ch_ptr[i] == ch_len[i] - 8'd1) ? 8'd0 : ch_ptr[i] + 8'd1;
          end else begin
            ch_cnt[i] <= ch_cnt[i] + 8'd1;
          end
        end
      end
    end
  end

endmodule
